muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit beside the ALU in the MIPS execute stage.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } muldiv_state_t;

  // True for the two-operand signed forms (MULT, DIV).
  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for either divide form.
  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide loop.
// acc holds {high half, low half}; b is the (magnitude) multiplier or divisor.
//   mul: add b into the high half when the low bit is set, then shift right.
//   div: shift left, trial-subtract b from the high half, restore on borrow.
module muldiv_step #(
  parameter int n = 32
) (
  input  logic           is_div,
  input  logic [2*n-1:0] acc,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] acc_next
);

  logic [n:0] sum;
  logic [n:0] rem;
  logic [n:0] trial;

  // Single combinational step; the top level registers acc_next every RUN cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment first) so no latch can be inferred.
    sum      = {1'b0, acc[2*n-1:n]} + {1'b0, b};
    rem      = acc[2*n-1:n-1];
    trial    = rem - {1'b0, b};
    acc_next = acc;
    if (is_div) begin
      // The remainder is always below b, so on a borrow it fits in n bits.
      if (trial[n]) acc_next = {rem[n-1:0], acc[n-2:0], 1'b0};
      else          acc_next = {trial[n-1:0], acc[n-2:0], 1'b1};
    end else begin
      if (acc[0]) acc_next = {sum, acc[n-1:1]};
      else        acc_next = {1'b0, acc[2*n-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in FIX.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  muldiv_op_t   op,
  input  logic [n-1:0] srca,
  input  logic [n-1:0] srcb,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int cw = $clog2(n + 1);

  muldiv_state_t  state;
  muldiv_op_t     op_q;
  logic [2*n-1:0] acc;
  logic [n-1:0]   opb;
  logic [cw-1:0]  count;
  logic           neg_lo;   // negate product / quotient
  logic           neg_hi;   // negate remainder
  logic           dbz;      // divisor was zero

  logic           is_div;
  logic           a_neg;
  logic           b_neg;
  logic [2*n-1:0] acc_next;
  logic [n-1:0]   fix_hi;
  logic [n-1:0]   fix_lo;

  assign is_div = is_div_op(op_q);
  assign a_neg  = is_signed_op(op_q) && acc[n-1];
  assign b_neg  = is_signed_op(op_q) && opb[n-1];

  muldiv_step #(.n(n)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .b        (opb),
    .acc_next (acc_next)
  );

  // Sign fixup of the finished magnitude result.
  always_comb begin
    fix_hi = acc[2*n-1:n];
    fix_lo = acc[n-1:0];
    if (!is_div) begin
      {fix_hi, fix_lo} = neg_lo ? -acc : acc;
    end else begin
      fix_lo = dbz ? {n{1'b1}} : (neg_lo ? -acc[n-1:0] : acc[n-1:0]);
      fix_hi = neg_hi ? -acc[2*n-1:n] : acc[2*n-1:n];
    end
  end

  // FSM, datapath registers and HI/LO, all with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    if (reset) begin
      state       <= IDLE;
      op_q        <= MD_MULT;
      acc         <= '0;
      opb         <= '0;
      count       <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // start wins over a simultaneous mthi/mtlo.
            op_q  <= op;
            acc   <= {{n{1'b0}}, srca};
            opb   <= srcb;
            busy  <= 1'b1;
            state <= PREP;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        PREP: begin
          if (a_neg) acc[n-1:0] <= -acc[n-1:0];
          if (b_neg) opb <= -opb;
          neg_lo <= a_neg ^ b_neg;
          neg_hi <= a_neg && is_div;
          dbz    <= is_div && (opb == '0);
          count  <= cw'(n);
          state  <= RUN;
        end
        RUN: begin
          acc   <= acc_next;
          count <= count - cw'(1);
          if (count == cw'(1)) state <= FIX;
        end
        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= dbz;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int n = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] srca, srcb;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  muldiv_unit #(.n(n)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .srca        (srca),
    .srcb        (srcb),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, m;
    logic [63:0] r, q64, m64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          m   = sa % sb;
          q64 = 64'(q);
          m64 = 64'(m);
          r   = {m64[31:0], q64[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Drive a start for one cycle; operands are scrambled afterwards.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = muldiv_op_t'(o);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    srca  = $urandom;
    srcb  = $urandom;
    cyc   = 0;
  endtask

  // Wait (bounded) for done, checking busy, latency and the result.
  task automatic finish_op(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
    for (int g = 0; g < 3 * n; g++) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      check({tag, " busy"}, 64'(busy), 64'd1);
    end
    check({tag, " latency"}, 64'(cyc), 64'(n + 3));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] exp;
    int          seen;

    reset = 1'b1; start = 1'b0; op = MD_MULT; srca = '0; srcb = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    // 1: MULT 7 * -3
    launch(2'b00, 32'd7, 32'hFFFF_FFFD);
    finish_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // 2: MULTU max*max, DIV -7/2
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // 3: DIVU by zero; flag lasts exactly the done cycle
    launch(2'b11, 32'd100, 32'd0);
    finish_op("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("dbz_pulse_end", 64'(div_by_zero), 64'd0);
    check("done_pulse_end", 64'(done), 64'd0);

    // Signed divide by zero keeps the dividend in hi
    launch(2'b10, 32'hFFFF_FF00, 32'd0);
    finish_op("div_zero", 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);

    // 4: overflow case wraps
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

    // 5: start and mthi during an operation are ignored
    launch(2'b00, 32'd3, 32'd5);
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    op = MD_DIVU; srca = 32'd9; srcb = 32'd3; start = 1'b1;
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0;
    finish_op("ignored_inputs", 32'd0, 32'd15, 1'b0);
    // Back-to-back start in the done cycle
    launch(2'b11, 32'd9, 32'd3);
    finish_op("back_to_back", 32'd0, 32'd3, 1'b0);

    // mthi + mtlo together; then start + mthi: start wins
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0001;
    @(posedge clk);
    #1 mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    check("mthi_mtlo hi", 64'(hi), 64'h5A5A_0001);
    check("mthi_mtlo lo", 64'(lo), 64'h5A5A_0001);
    mthi = 1'b1; wdata = 32'h0BAD_0BAD;
    launch(2'b01, 32'd6, 32'd7);
    mthi = 1'b0;
    @(negedge clk);
    cyc++;
    check("start_wins hi", 64'(hi), 64'h5A5A_0001);
    finish_op("start_wins", 32'd0, 32'd42, 1'b0);

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      exp = model(ro, ra, rb);
      launch(ro, ra, rb);
      finish_op($sformatf("rand%0d op%0d", i, ro), exp[63:32], exp[31:0],
                ro[1] && (rb == 32'd0));
    end

    // 6: reset mid-DIV discards the result
    launch(2'b10, 32'd1000, 32'd7);
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    seen = 0;
    for (int k = 0; k < n + 5; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midreset no_done", 64'(seen), 64'd0);
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk);
    #1 mtlo = 1'b0;
    @(negedge clk);
    check("mtlo lo", 64'(lo), 64'h0000_1234);
    check("mtlo hi", 64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
